// File: rtl/dlx_pkg.sv
// Shared DLX definitions used by the register-file write-side logic.
package dlx_pkg;

  localparam int REG_W = 5;
  localparam int XLEN  = 32;
  localparam logic [REG_W-1:0] R0 = '0;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  data;
  } wb_entry_t;

endpackage

// File: rtl/dlx_sync_fifo.sv
// Small synchronous FIFO of writeback entries; DEPTH must be a power of two.
module dlx_sync_fifo
  import dlx_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      push,
  input  wb_entry_t push_data,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output wb_entry_t head
);

  localparam int AW = $clog2(DEPTH);

  wb_entry_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;

  logic do_push;
  logic do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dlx_wb_arbiter.sv
// Drives the register-file write port from the writeback stage and the
// long-latency unit result FIFO, and tracks pending long-unit destinations.
module dlx_wb_arbiter
  import dlx_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wb_valid,
  input  logic [REG_W-1:0] wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             lu_valid,
  output logic             lu_ready,
  input  logic [REG_W-1:0] lu_rd,
  input  logic [XLEN-1:0]  lu_data,
  input  logic             iss_valid,
  input  logic [REG_W-1:0] iss_rd,
  input  logic [REG_W-1:0] q_rs1,
  input  logic [REG_W-1:0] q_rs2,
  output logic             q_busy1,
  output logic             q_busy2,
  output logic [REG_W-1:0] rf_rd,
  output logic [XLEN-1:0]  rf_data,
  output logic             stall_req
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  logic        fifo_full;
  logic        fifo_empty;
  logic        pop;
  logic        wb_write;
  wb_entry_t   fifo_head;
  wb_entry_t   lu_entry;
  logic [31:0] pending;
  logic [31:0] pending_next;
  logic [WW-1:0] wait_cnt;

  assign lu_entry = '{rd: lu_rd, data: lu_data};
  assign lu_ready = !fifo_full;
  assign wb_write = wb_valid && (wb_rd != R0);
  assign pop      = !wb_write && !fifo_empty;

  dlx_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (lu_valid && lu_ready),
    .push_data (lu_entry),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  // The writeback stage cannot stall, so it always wins the port; a write to r0 is idle.
  always_comb begin
    rf_rd   = R0;
    rf_data = '0;
    if (wb_write) begin
      rf_rd   = wb_rd;
      rf_data = wb_data;
    end else if (!fifo_empty) begin
      rf_rd   = fifo_head.rd;
      rf_data = fifo_head.data;
    end
  end

  // Clear comes first so a same-cycle issue to the popped register keeps it pending.
  always_comb begin
    pending_next = pending;
    if (pop)                          pending_next[fifo_head.rd] = 1'b0;
    if (iss_valid && iss_rd != R0)    pending_next[iss_rd]       = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending  <= '0;
      wait_cnt <= '0;
    end else begin
      pending <= pending_next;
      if (fifo_empty || pop)       wait_cnt <= '0;
      else if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + WW'(1);
    end
  end

  assign q_busy1   = pending[q_rs1];
  assign q_busy2   = pending[q_rs2];
  assign stall_req = fifo_full || (wait_cnt == WAIT_MAX);

endmodule

// File: tb/tb_dlx_wb_arbiter.sv
// Scoreboard bench for dlx_wb_arbiter: a queue-based reference model predicts
// each cycle's write port and status outputs; a monitor compares them.
module tb_dlx_wb_arbiter;
  import dlx_pkg::*;

  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        lu_valid = 1'b0;
  logic        lu_ready;
  logic [4:0]  lu_rd = '0;
  logic [31:0] lu_data = '0;
  logic        iss_valid = 1'b0;
  logic [4:0]  iss_rd = '0;
  logic [4:0]  q_rs1 = '0;
  logic [4:0]  q_rs2 = '0;
  logic        q_busy1;
  logic        q_busy2;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;
  logic        stall_req;

  dlx_wb_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .lu_valid  (lu_valid),
    .lu_ready  (lu_ready),
    .lu_rd     (lu_rd),
    .lu_data   (lu_data),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .q_rs1     (q_rs1),
    .q_rs2     (q_rs2),
    .q_busy1   (q_busy1),
    .q_busy2   (q_busy2),
    .rf_rd     (rf_rd),
    .rf_data   (rf_data),
    .stall_req (stall_req)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        ready;
    logic        stall;
    logic        busy1;
    logic        busy2;
  } exp_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  exp_t expQ[$];
  ent_t modelQ[$];
  bit   pend[32];
  int   waitCnt = 0;
  bit   lastStall = 0;
  int   checks = 0;
  int   passes = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
  endtask

  // Advance the model across the edge that just occurred, using the inputs held during the last cycle.
  task automatic updateModel();
    bit   wbWrite;
    bit   popped;
    bit   wasEmpty;
    ent_t h;
    wbWrite  = wb_valid && wb_rd != 0;
    wasEmpty = (modelQ.size() == 0);
    popped   = !wbWrite && !wasEmpty;
    if (popped) begin
      h = modelQ.pop_front();
      pend[h.rd] = 0;
    end
    if (lu_valid && (modelQ.size() + (popped ? 1 : 0)) < DEPTH) modelQ.push_back('{lu_rd, lu_data});
    if (iss_valid && iss_rd != 0) pend[iss_rd] = 1;
    if (wasEmpty || popped) waitCnt = 0;
    else if (waitCnt < MAX_WAIT) waitCnt++;
  endtask

  function automatic exp_t predict();
    exp_t e;
    e.rd = 0;
    e.data = 0;
    if (wb_valid && wb_rd != 0) begin
      e.rd = wb_rd;
      e.data = wb_data;
    end else if (modelQ.size() > 0) begin
      e.rd = modelQ[0].rd;
      e.data = modelQ[0].data;
    end
    e.ready = (modelQ.size() < DEPTH);
    e.stall = (modelQ.size() == DEPTH) || (waitCnt == MAX_WAIT);
    e.busy1 = pend[q_rs1];
    e.busy2 = pend[q_rs2];
    return e;
  endfunction

  task automatic applyStimulus(
    input logic wbv, input logic [4:0] wbr, input logic [31:0] wbd,
    input logic luv, input logic [4:0] lur, input logic [31:0] lud,
    input logic isv, input logic [4:0] isr,
    input logic [4:0] rs1, input logic [4:0] rs2);
    exp_t e;
    @(posedge clk);
    #1;
    updateModel();
    wb_valid  = lastStall ? 1'b0 : wbv;
    wb_rd     = wbr;
    wb_data   = wbd;
    lu_valid  = luv;
    lu_rd     = lur;
    lu_data   = lud;
    iss_valid = isv;
    iss_rd    = isr;
    q_rs1     = rs1;
    q_rs2     = rs2;
    e = predict();
    lastStall = e.stall;
    expQ.push_back(e);
  endtask

  task automatic resetPulse(input logic [4:0] rs1, input logic [4:0] rs2);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    modelQ.delete();
    foreach (pend[i]) pend[i] = 0;
    waitCnt   = 0;
    wb_valid  = 0; wb_rd = 0; wb_data = 0;
    lu_valid  = 0; lu_rd = 0; lu_data = 0;
    iss_valid = 0; iss_rd = 0;
    q_rs1 = rs1; q_rs2 = rs2;
    lastStall = 0;
    expQ.push_back('{5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      checkOutput("rf_rd",     32'(rf_rd),     32'(e.rd));
      checkOutput("rf_data",   rf_data,        e.data);
      checkOutput("lu_ready",  32'(lu_ready),  32'(e.ready));
      checkOutput("stall_req", 32'(stall_req), 32'(e.stall));
      checkOutput("q_busy1",   32'(q_busy1),   32'(e.busy1));
      checkOutput("q_busy2",   32'(q_busy2),   32'(e.busy2));
    end
  end

  initial begin
    int guard;
    resetPulse(0, 0);

    // Plain writeback pass-through.
    applyStimulus(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);

    // Issue r7, later its long result drains on an idle writeback cycle.
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
    applyStimulus(0, 0, 0, 1, 7, 32'h12345678, 0, 0, 7, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);

    // Fill the FIFO under continuous writeback, then drain on the forced bubbles.
    applyStimulus(1, 3, 32'hA0A0A0A0, 1, 10, 32'hB0B0B0B0, 1, 10, 10, 11);
    applyStimulus(1, 4, 32'hC0C0C0C0, 1, 11, 32'hD0D0D0D0, 1, 11, 10, 11);
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 6, 32'hE0E0E0E0 + i, 0, 0, 0, 0, 0, 10, 11);

    // One buffered result starves until the wait counter saturates.
    applyStimulus(1, 8, 32'h1111, 1, 12, 32'h2222, 1, 12, 12, 0);
    for (int i = 0; i < 8; i++)
      applyStimulus(1, 8, 32'h3000 + i, 0, 0, 0, 0, 0, 12, 0);

    // Pop of r9 coinciding with a new issue to r9 keeps it pending.
    applyStimulus(1, 2, 32'h5555, 1, 9, 32'h9999, 1, 9, 9, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
    // Writeback to r0 is idle, so the FIFO drains.
    applyStimulus(1, 2, 32'h6666, 1, 0, 32'h7777, 0, 0, 9, 0);
    applyStimulus(1, 0, 32'hFFFF, 0, 0, 0, 0, 0, 9, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 9, 0);

    // Two buffered entries discarded by a mid-operation reset.
    applyStimulus(1, 1, 32'h1, 1, 13, 32'hAAAA, 1, 13, 13, 14);
    applyStimulus(1, 1, 32'h2, 1, 14, 32'hBBBB, 1, 14, 13, 14);
    resetPulse(13, 14);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 13, 14);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 9) < 7), 5'($urandom), $urandom,
                    ($urandom_range(0, 1) == 1), 5'($urandom), $urandom,
                    ($urandom_range(0, 9) < 3), 5'($urandom),
                    5'($urandom), 5'($urandom));
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    guard = 0;
    while (expQ.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    if (expQ.size() > 0) begin
      checks++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
    end
    @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
